// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file (REG0_ZERO_EN selects a hard-wired zero entry 0).
package regfile_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    // Base bit index of lane idx in a flat bus of w-bit lanes.
    function automatic int rd_slice(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/registerfile_param_if.sv
// Register file access bus: one write port, NUM_RD read ports, bulk-clear control.
interface registerfile_param_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
);
    logic                     we;
    logic [ADDR_W-1:0]        addre_wr;
    logic [DATA_W-1:0]        D;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] addre_rd;
    logic [NUM_RD*DATA_W-1:0] Q;
    logic [NUM_RD-1:0]        q_valid;
    logic                     clr;
    logic                     busy;

    modport master (
        output we, addre_wr, D, re, addre_rd, clr,
        input  Q, q_valid, busy
    );

    modport slave (
        input  we, addre_wr, D, re, addre_rd, clr,
        output Q, q_valid, busy
    );
endinterface

// File: rtl/regfile_rd_port.sv
// One read port: clear/bypass/storage select and the Q/q_valid output register.
// Latency 1 cycle; no backpressure, q_valid pulses for each accepted read.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic              clearing,
    input  logic              byp_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [DATA_W-1:0] mem_dat,
    output logic [DATA_W-1:0] q,
    output logic              q_valid
);
    logic [DATA_W-1:0] rd_dat;

    // Clearing overrides bypass, bypass overrides storage.
    always_comb begin
        rd_dat = mem_dat;
        if (byp_en && (wr_addr == addr)) rd_dat = wr_dat;
        if (clearing)                    rd_dat = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= re;
            if (re) q <= rd_dat;
        end
    end
endmodule

// File: rtl/registerfile_param.sv
// Register file, 1 write / NUM_RD registered read ports, write-through bypass, DEPTH-cycle bulk clear.
// Latency: reads 1 cycle; during clear (busy=1) writes are dropped and reads return 0. REG0_ZERO_EN: entry 0 reads 0.
module registerfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    registerfile_param_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state_q, state_nxt;
    logic [ADDR_W-1:0] clr_ptr;
    logic              wr_en;
    logic              clearing;

    assign clearing = (state_q == ST_CLEAR);
    assign bus.busy = clearing;

    // A clear request in the same cycle pre-empts the write.
    always_comb begin
        wr_en = bus.we && (state_q == ST_IDLE) && !bus.clr;
`ifdef REG0_ZERO_EN
        wr_en = wr_en && (bus.addre_wr != '0);
`endif
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (bus.clr) state_nxt = ST_CLEAR;
            ST_CLEAR: if (clr_ptr == ADDR_W'(DEPTH - 1)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nxt;
    end

    // The pointer wraps to 0 naturally after the last entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           clr_ptr <= '0;
        else if (clearing) clr_ptr <= clr_ptr + ADDR_W'(1);
        else               clr_ptr <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clearing) begin
            mem[clr_ptr] <= '0;
        end else if (wr_en) begin
            mem[bus.addre_wr] <= bus.D;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = bus.addre_rd[rd_slice(i, ADDR_W) +: ADDR_W];

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .clk      (clk),
            .rst      (rst),
            .re       (bus.re[i]),
            .addr     (addr),
            .clearing (clearing),
            .byp_en   (wr_en),
            .wr_addr  (bus.addre_wr),
            .wr_dat   (bus.D),
            .mem_dat  (mem[addr]),
            .q        (bus.Q[rd_slice(i, DATA_W) +: DATA_W]),
            .q_valid  (bus.q_valid[i])
        );
    end
endmodule

// File: tb/tb_registerfile_param.sv
// Directed bench for registerfile_param: vector table plus clear / reset-mid-clear / entry-0 sequences.
module tb_registerfile_param;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    registerfile_param_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) bus ();

    registerfile_param #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] d;
        logic [1:0]  re;
        logic [2:0]  a0;
        logic [2:0]  a1;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [1:0]  ev;
    } vec_t;

    vec_t tbl [8];

`ifdef REG0_ZERO_EN
    localparam logic [15:0] EXP_R0 = 16'h0000;
`else
    localparam logic [15:0] EXP_R0 = 16'hFFFF;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] d,
                         input logic [1:0] re, input logic [2:0] a0, input logic [2:0] a1,
                         input logic clr);
        bus.we       = we;
        bus.addre_wr = wa;
        bus.D        = d;
        bus.re       = re;
        bus.addre_rd = {a1, a0};
        bus.clr      = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_all_zero(input string name);
        for (int a = 0; a < 8; a += 2) begin
            drive(1'b0, 3'd0, 16'h0, 2'b11, 3'(a), 3'(a + 1), 1'b0);
            step();
            chk({name, "_p0"}, {16'h0, bus.Q[15:0]}, 32'h0);
            chk({name, "_p1"}, {16'h0, bus.Q[31:16]}, 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 2'b00, 3'd0, 3'd0, 1'b0);

        //             we    wa    d         re     a0    a1    e0        e1        ev
        tbl[0] = '{1'b1, 3'd1, 16'd10,   2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'b00};
        tbl[1] = '{1'b1, 3'd3, 16'd8,    2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'b00};
        tbl[2] = '{1'b0, 3'd0, 16'h0,    2'b11, 3'd3, 3'd2, 16'd8,    16'h0000, 2'b11};
        tbl[3] = '{1'b1, 3'd5, 16'h1234, 2'b01, 3'd5, 3'd1, 16'h1234, 16'h0000, 2'b01};
        tbl[4] = '{1'b0, 3'd0, 16'h0,    2'b11, 3'd5, 3'd1, 16'h1234, 16'd10,   2'b11};
        tbl[5] = '{1'b0, 3'd0, 16'h0,    2'b10, 3'd0, 3'd3, 16'h1234, 16'd8,    2'b10};
        tbl[6] = '{1'b0, 3'd0, 16'h0,    2'b00, 3'd0, 3'd0, 16'h1234, 16'd8,    2'b00};
        tbl[7] = '{1'b1, 3'd2, 16'hABCD, 2'b11, 3'd2, 3'd2, 16'hABCD, 16'hABCD, 2'b11};

        #1 rst = 1'b1;
        #2;
        chk("rst_q",     {16'h0, bus.Q[31:16] | bus.Q[15:0]}, 32'h0);
        chk("rst_qv",    {30'h0, bus.q_valid}, 32'h0);
        chk("rst_busy",  {31'h0, bus.busy}, 32'h0);
        #1 rst = 1'b0;
        step();

        for (int v = 0; v < 8; v++) begin
            drive(tbl[v].we, tbl[v].wa, tbl[v].d, tbl[v].re, tbl[v].a0, tbl[v].a1, 1'b0);
            step();
            chk($sformatf("vec%0d_q0", v), {16'h0, bus.Q[15:0]},  {16'h0, tbl[v].e0});
            chk($sformatf("vec%0d_q1", v), {16'h0, bus.Q[31:16]}, {16'h0, tbl[v].e1});
            chk($sformatf("vec%0d_qv", v), {30'h0, bus.q_valid},  {30'h0, tbl[v].ev});
        end

        // Entry 0: bypass read, then stored read.
        drive(1'b1, 3'd0, 16'hFFFF, 2'b01, 3'd0, 3'd0, 1'b0);
        step();
        chk("r0_bypass", {16'h0, bus.Q[15:0]}, {16'h0, EXP_R0});
        drive(1'b0, 3'd0, 16'h0, 2'b01, 3'd0, 3'd0, 1'b0);
        step();
        chk("r0_read", {16'h0, bus.Q[15:0]}, {16'h0, EXP_R0});

        // Bulk clear with a write attempt and reads throughout.
        for (int a = 0; a < 8; a++) begin
            drive(1'b1, 3'(a), 16'h1000 + 16'(a), 2'b00, 3'd0, 3'd0, 1'b0);
            step();
        end
        drive(1'b0, 3'd0, 16'h0, 2'b00, 3'd0, 3'd0, 1'b1);
        step();
        busy_cnt = 0;
        while (bus.busy && busy_cnt < 20) begin
            drive(1'b1, 3'd2, 16'h5555, 2'b11, 3'd1, 3'd2, 1'b1);
            step();
            busy_cnt++;
            chk("clr_rd_p0", {16'h0, bus.Q[15:0]},  32'h0);
            chk("clr_rd_p1", {16'h0, bus.Q[31:16]}, 32'h0);
        end
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd8);
        read_all_zero("after_clr");

        // Reset in the middle of a clear sequence.
        drive(1'b1, 3'd4, 16'h7777, 2'b00, 3'd0, 3'd0, 1'b0);
        step();
        drive(1'b0, 3'd0, 16'h0, 2'b01, 3'd4, 3'd0, 1'b0);
        step();
        chk("pre_rst_q0", {16'h0, bus.Q[15:0]}, 32'h7777);
        drive(1'b0, 3'd0, 16'h0, 2'b00, 3'd0, 3'd0, 1'b1);
        step();
        drive(1'b0, 3'd0, 16'h0, 2'b00, 3'd0, 3'd0, 1'b0);
        step();
        step();
        step();
        chk("mid_clr_busy", {31'h0, bus.busy}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("mid_rst_q",    {16'h0, bus.Q[15:0]}, 32'h0);
        chk("mid_rst_qv",   {30'h0, bus.q_valid}, 32'h0);
        #2 rst = 1'b0;
        step();
        read_all_zero("after_rst");
        drive(1'b1, 3'd6, 16'h4242, 2'b00, 3'd0, 3'd0, 1'b0);
        step();
        drive(1'b0, 3'd0, 16'h0, 2'b10, 3'd0, 3'd6, 1'b0);
        step();
        chk("post_rst_wr", {16'h0, bus.Q[31:16]}, 32'h4242);
        chk("post_rst_qv", {30'h0, bus.q_valid}, 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
